// File: rtl/sumador_serie_pkg.sv
// sumador_serie_pkg: shared types and defaults for the bit-serial adder.
// Optional feature macro: SUMADOR_SERIE_RESTA_EN (adds subtraction via i_resta).
package sumador_serie_pkg;

  // Default operand/sum width in bits (legal range 2..32).
  localparam int ANCHO_DEF = 8;

  // Controller states.
  typedef enum logic [1:0] {
    REPOSO    = 2'd0,
    SUMANDO   = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

  // Operand b as seen by the shared cell: inverted when subtracting so that
  // a + ~b + 1 yields a - b.
  function automatic logic [31:0] operando_b_efectivo(input logic [31:0] b,
                                                      input logic      resta);
    logic [31:0] r;
    if (resta) begin
      r = ~b;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/sumador_serie_full_adder.sv
// Shared one-bit adder cell for sumador_serie: a full adder built from two
// half adders and an OR of their carries.
// Optional feature macro of the block: SUMADOR_SERIE_RESTA_EN (no effect here).

module half_adder
  import sumador_serie_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

module full_adder
  import sumador_serie_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);

  logic s0_s;
  logic c0_s;
  logic c1_s;

  // First stage: a + b.
  half_adder u_ha0 (
    .i_a (i_a),
    .i_b (i_b),
    .o_s (s0_s),
    .o_c (c0_s)
  );

  // Second stage: partial sum + carry-in.
  half_adder u_ha1 (
    .i_a (s0_s),
    .i_b (i_ci),
    .o_s (o_s),
    .o_c (c1_s)
  );

  // At most one of the two half-adder carries can be set, so OR merges them.
  assign o_co = c0_s | c1_s;

endmodule

// File: rtl/sumador_serie.sv
// sumador_serie: bit-serial ANCHO-bit adder sharing one full-adder cell.
// Operands are accepted on a valid/ready handshake, walked LSB-first through
// the cell one bit per clock, and the sum plus final carry are returned on a
// second valid/ready handshake.
// Optional feature macro: SUMADOR_SERIE_RESTA_EN adds input i_resta; when it
// is 1 at acceptance the block computes a - b and o_acarreo=1 means no borrow.

module sumador_serie
  import sumador_serie_pkg::*;
#(
  parameter int ANCHO = ANCHO_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valido,
  output logic             o_listo,
  input  logic [ANCHO-1:0] i_operando_a,
  input  logic [ANCHO-1:0] i_operando_b,
  output logic             o_valido,
  input  logic             i_listo,
  output logic [ANCHO-1:0] o_suma,
  output logic             o_acarreo
`ifdef SUMADOR_SERIE_RESTA_EN
  ,
  input  logic             i_resta
`endif
);

  localparam int CNT_W = $clog2(ANCHO);
  localparam logic [CNT_W-1:0] ULTIMO_BIT = CNT_W'(ANCHO - 1);

  // Controller state and handshake flags.
  estado_t          estado_q, estado_d;
  logic             listo_q, listo_d;
  logic             valido_q, valido_d;

  // Datapath registers.
  logic [ANCHO-1:0] op_a_q, op_a_d;
  logic [ANCHO-1:0] op_b_q, op_b_d;
  logic [ANCHO-1:0] suma_q, suma_d;
  logic             carry_q, carry_d;
  logic             acarreo_q, acarreo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Shared cell connections.
  logic             fa_s_s;
  logic             fa_co_s;

  // Load-time operation selection.
  logic             resta_s;
  logic [31:0]      b_ext_s;
  logic [ANCHO-1:0] b_carga_s;

`ifdef SUMADOR_SERIE_RESTA_EN
  assign resta_s = i_resta;
`else
  assign resta_s = 1'b0;
`endif

  assign b_ext_s   = operando_b_efectivo(32'(i_operando_b), resta_s);
  assign b_carga_s = b_ext_s[ANCHO-1:0];

  // The single adder cell always looks at the current LSBs and the carry.
  full_adder u_celda (
    .i_a  (op_a_q[0]),
    .i_b  (op_b_q[0]),
    .i_ci (carry_q),
    .o_s  (fa_s_s),
    .o_co (fa_co_s)
  );

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    estado_d  = estado_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    suma_d    = suma_q;
    carry_d   = carry_q;
    acarreo_d = acarreo_q;
    cnt_d     = cnt_q;

    case (estado_q)
      REPOSO: begin
        if (i_valido && listo_q) begin
          op_a_d   = i_operando_a;
          op_b_d   = b_carga_s;
          carry_d  = resta_s;
          cnt_d    = {CNT_W{1'b0}};
          estado_d = SUMANDO;
        end else begin
          estado_d = REPOSO;
        end
      end

      SUMANDO: begin
        // Sum bit enters from the MSB side so bit 0 lands at position 0
        // after ANCHO shifts.
        suma_d    = {fa_s_s, suma_q[ANCHO-1:1]};
        op_a_d    = {1'b0, op_a_q[ANCHO-1:1]};
        op_b_d    = {1'b0, op_b_q[ANCHO-1:1]};
        carry_d   = fa_co_s;
        // Reported carry is kept apart from the working carry so that
        // loading a new operation never disturbs the visible result.
        acarreo_d = fa_co_s;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == ULTIMO_BIT) begin
          estado_d = RESULTADO;
        end else begin
          estado_d = SUMANDO;
        end
      end

      RESULTADO: begin
        if (valido_q && i_listo) begin
          estado_d = REPOSO;
        end else begin
          estado_d = RESULTADO;
        end
      end

      default: begin
        estado_d = REPOSO;
      end
    endcase

    // Handshake flags are registered copies of the next-state decode.
    listo_d  = (estado_d == REPOSO);
    valido_d = (estado_d == RESULTADO);
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      estado_q  <= REPOSO;
      listo_q   <= 1'b1;
      valido_q  <= 1'b0;
      op_a_q    <= {ANCHO{1'b0}};
      op_b_q    <= {ANCHO{1'b0}};
      suma_q    <= {ANCHO{1'b0}};
      carry_q   <= 1'b0;
      acarreo_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      estado_q  <= estado_d;
      listo_q   <= listo_d;
      valido_q  <= valido_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      suma_q    <= suma_d;
      carry_q   <= carry_d;
      acarreo_q <= acarreo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_listo   = listo_q;
  assign o_valido  = valido_q;
  assign o_suma    = suma_q;
  assign o_acarreo = acarreo_q;

endmodule

// File: tb/tb_sumador_serie.sv
// Self-checking bench for sumador_serie (ANCHO=8). Expected results come from
// an arithmetic model and are queued at acceptance, then popped and compared
// when the block presents its result. Define SUMADOR_SERIE_RESTA_EN to also
// exercise subtraction.

module tb_sumador_serie;

  localparam int ANCHO = 8;

  logic             clk;
  logic             rst;
  logic             i_valido;
  logic             o_listo;
  logic [ANCHO-1:0] op_a;
  logic [ANCHO-1:0] op_b;
  logic             o_valido;
  logic             i_listo;
  logic [ANCHO-1:0] o_suma;
  logic             o_acarreo;
  logic             i_resta;

  int checks;
  int failures;

  logic [ANCHO:0] sb_q[$];

  sumador_serie #(.ANCHO(ANCHO)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valido     (i_valido),
    .o_listo      (o_listo),
    .i_operando_a (op_a),
    .i_operando_b (op_b),
    .o_valido     (o_valido),
    .i_listo      (i_listo),
    .o_suma       (o_suma),
    .o_acarreo    (o_acarreo)
`ifdef SUMADOR_SERIE_RESTA_EN
    ,
    .i_resta      (i_resta)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [ANCHO:0] modelo(input logic [ANCHO-1:0] a,
                                            input logic [ANCHO-1:0] b,
                                            input logic resta);
    logic [ANCHO:0] r;
    if (resta) r = {1'b0, a} + {1'b0, ~b} + {{ANCHO{1'b0}}, 1'b1};
    else       r = {1'b0, a} + {1'b0, b};
    return r;
  endfunction

  task automatic avanzar();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++; if (o_listo !== 1'b1)   begin failures++; $display("FAIL reset_listo got=%b exp=1", o_listo); end
    checks++; if (o_valido !== 1'b0)  begin failures++; $display("FAIL reset_valido got=%b exp=0", o_valido); end
    checks++; if (o_suma !== 8'h00)   begin failures++; $display("FAIL reset_suma got=%h exp=00", o_suma); end
    checks++; if (o_acarreo !== 1'b0) begin failures++; $display("FAIL reset_acarreo got=%b exp=0", o_acarreo); end
    @(negedge clk);
    rst = 1'b0;
    avanzar();
  endtask

  // Single operation: accept, measure latency, compare, complete handshake.
  task automatic operar(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                        input logic resta, input string nombre);
    logic [ANCHO:0] esp;
    int lat;
    checks++; if (o_listo !== 1'b1) begin failures++; $display("FAIL %s_listo_pre got=%b exp=1", nombre, o_listo); end
    op_a = a; op_b = b; i_resta = resta; i_valido = 1'b1;
    avanzar();
    sb_q.push_back(modelo(a, b, resta));
    i_valido = 1'b0;
    checks++; if (o_listo !== 1'b0) begin failures++; $display("FAIL %s_listo_busy got=%b exp=0", nombre, o_listo); end
    lat = 0;
    while (o_valido !== 1'b1 && lat < 40) begin
      avanzar();
      lat++;
    end
    checks++; if (lat !== ANCHO) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", nombre, lat, ANCHO); end
    esp = sb_q.pop_front();
    checks++; if (o_suma !== esp[ANCHO-1:0]) begin failures++; $display("FAIL %s_suma got=%h exp=%h", nombre, o_suma, esp[ANCHO-1:0]); end
    checks++; if (o_acarreo !== esp[ANCHO]) begin failures++; $display("FAIL %s_acarreo got=%b exp=%b", nombre, o_acarreo, esp[ANCHO]); end
    i_listo = 1'b1;
    avanzar();
    i_listo = 1'b0;
    checks++; if (o_valido !== 1'b0 || o_listo !== 1'b1) begin
      failures++; $display("FAIL %s_post_hs got valido=%b listo=%b exp 0/1", nombre, o_valido, o_listo);
    end
  endtask

  task automatic test_add_basic();
    operar(8'h00, 8'h00, 1'b0, "zero");
    operar(8'hFF, 8'h01, 1'b0, "wrap");
    operar(8'h3C, 8'hE7, 1'b0, "mixed");
  endtask

  // Producer and consumer always ready: two operations at minimum interval.
  task automatic test_back_to_back();
    int acc_e[2];
    int n_acc, n_res;
    logic acc, hs;
    logic [ANCHO:0] esp;
    acc_e[0] = 0; acc_e[1] = 0;
    n_acc = 0; n_res = 0;
    op_a = 8'hA5; op_b = 8'h5A; i_resta = 1'b0;
    i_valido = 1'b1; i_listo = 1'b1;
    for (int e = 0; e < 60 && n_res < 2; e++) begin
      acc = (o_listo === 1'b1) && (i_valido === 1'b1);
      hs  = (o_valido === 1'b1) && (i_listo === 1'b1);
      if (acc) begin
        sb_q.push_back(modelo(op_a, op_b, 1'b0));
        if (n_acc < 2) acc_e[n_acc] = e;
        n_acc++;
      end
      if (hs) begin
        esp = sb_q.pop_front();
        checks++; if (o_suma !== esp[ANCHO-1:0]) begin failures++; $display("FAIL b2b_suma%0d got=%h exp=%h", n_res, o_suma, esp[ANCHO-1:0]); end
        checks++; if (o_acarreo !== esp[ANCHO]) begin failures++; $display("FAIL b2b_acarreo%0d got=%b exp=%b", n_res, o_acarreo, esp[ANCHO]); end
        n_res++;
      end
      avanzar();
      if (acc) begin
        if (n_acc == 1) begin op_a = 8'h80; op_b = 8'h80; end
        else i_valido = 1'b0;
      end
    end
    i_valido = 1'b0; i_listo = 1'b0;
    checks++; if (n_res !== 2) begin failures++; $display("FAIL b2b_results got=%0d exp=2", n_res); end
    checks++; if (acc_e[1] - acc_e[0] !== 10) begin failures++; $display("FAIL b2b_interval got=%0d exp=10", acc_e[1] - acc_e[0]); end
  endtask

  task automatic test_backpressure();
    logic [ANCHO:0] esp;
    int lat;
    op_a = 8'h12; op_b = 8'h34; i_resta = 1'b0; i_valido = 1'b1; i_listo = 1'b0;
    avanzar();
    sb_q.push_back(modelo(8'h12, 8'h34, 1'b0));
    i_valido = 1'b0;
    lat = 0;
    while (o_valido !== 1'b1 && lat < 40) begin avanzar(); lat++; end
    checks++; if (lat !== ANCHO) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, ANCHO); end
    esp = sb_q.pop_front();
    // Offer a new operation while the result is stalled; it must be refused.
    op_a = 8'hFF; op_b = 8'hFF; i_valido = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++; if (o_valido !== 1'b1 || o_suma !== esp[ANCHO-1:0] || o_acarreo !== esp[ANCHO] || o_listo !== 1'b0) begin
        failures++; $display("FAIL bp_hold%0d got valido=%b suma=%h acarreo=%b listo=%b exp 1/%h/%b/0",
                             c, o_valido, o_suma, o_acarreo, o_listo, esp[ANCHO-1:0], esp[ANCHO]);
      end
      avanzar();
    end
    i_valido = 1'b0;
    checks++; if (o_suma !== esp[ANCHO-1:0]) begin failures++; $display("FAIL bp_suma got=%h exp=%h", o_suma, esp[ANCHO-1:0]); end
    i_listo = 1'b1;
    avanzar();
    i_listo = 1'b0;
    avanzar();
    avanzar();
    checks++; if (o_valido !== 1'b0 || o_listo !== 1'b1) begin
      failures++; $display("FAIL bp_no_accept got valido=%b listo=%b exp 0/1", o_valido, o_listo);
    end
  endtask

  task automatic test_reset_mid_op();
    op_a = 8'h55; op_b = 8'h11; i_resta = 1'b0; i_valido = 1'b1;
    avanzar();
    sb_q.push_back(modelo(8'h55, 8'h11, 1'b0));
    i_valido = 1'b0;
    avanzar(); avanzar(); avanzar();
    rst = 1'b1;
    #1;
    sb_q.delete();
    checks++; if (o_valido !== 1'b0) begin failures++; $display("FAIL rst_mid_valido got=%b exp=0", o_valido); end
    checks++; if (o_suma !== 8'h00)  begin failures++; $display("FAIL rst_mid_suma got=%h exp=00", o_suma); end
    checks++; if (o_listo !== 1'b1)  begin failures++; $display("FAIL rst_mid_listo got=%b exp=1", o_listo); end
    @(negedge clk);
    rst = 1'b0;
    avanzar();
    operar(8'h03, 8'h04, 1'b0, "after_rst");
  endtask

`ifdef SUMADOR_SERIE_RESTA_EN
  task automatic test_resta();
    operar(8'h05, 8'h07, 1'b1, "resta_borrow");
    operar(8'h07, 8'h05, 1'b1, "resta_ok");
    operar(8'h07, 8'h05, 1'b0, "resta_off");
  endtask
`endif

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; i_valido = 1'b0; i_listo = 1'b0; i_resta = 1'b0;
    op_a = 8'h00; op_b = 8'h00;
    test_reset();
    test_add_basic();
    test_back_to_back();
    avanzar();
    test_backpressure();
    test_reset_mid_op();
`ifdef SUMADOR_SERIE_RESTA_EN
    test_resta();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
